// File: rtl/tcp_misc_pkg.sv
// Shared types for the TCP transmit engine.
// Holds the transmit controller state encoding used by the control FSM.
package tcp_misc_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_REQ,
        ST_RD_RESP,
        ST_CALC,
        ST_OUTPUT
    } tcp_tx_ctrl_state_e;

endpackage

// File: rtl/tcp_tx_ctrl_if.sv
// Handshake and strobe bundle between the transmit controller and its neighbours
// (scheduler, state memories, datapath, packet assembler).
interface tcp_tx_ctrl_if #(
    parameter int CNT_W = 32
);
    logic             sched_tx_req_val;
    logic             tx_sched_req_rdy;
    logic             tx_state_rd_req_val;
    logic             tx_state_wr_req_val;
    logic             ctrl_datap_store_flowid;
    logic             ctrl_datap_store_state;
    logic             ctrl_datap_store_tuple;
    logic             ctrl_datap_store_calc;
    logic             datap_ctrl_produce_pkt;
    logic             proto_calc_tx_pkt_val;
    logic             tx_proto_calc_pkt_rdy;
    logic             tx_sched_update_val;
    logic             sched_tx_update_rdy;
    logic [CNT_W-1:0] tx_ctrl_skip_cnt;

    modport master (
        input  sched_tx_req_val,
        output tx_sched_req_rdy,
        output tx_state_rd_req_val,
        output tx_state_wr_req_val,
        output ctrl_datap_store_flowid,
        output ctrl_datap_store_state,
        output ctrl_datap_store_tuple,
        output ctrl_datap_store_calc,
        input  datap_ctrl_produce_pkt,
        output proto_calc_tx_pkt_val,
        input  tx_proto_calc_pkt_rdy,
        output tx_sched_update_val,
        input  sched_tx_update_rdy,
        output tx_ctrl_skip_cnt
    );

    modport slave (
        output sched_tx_req_val,
        input  tx_sched_req_rdy,
        input  tx_state_rd_req_val,
        input  tx_state_wr_req_val,
        input  ctrl_datap_store_flowid,
        input  ctrl_datap_store_state,
        input  ctrl_datap_store_tuple,
        input  ctrl_datap_store_calc,
        output datap_ctrl_produce_pkt,
        input  proto_calc_tx_pkt_val,
        output tx_proto_calc_pkt_rdy,
        input  tx_sched_update_val,
        output sched_tx_update_rdy,
        input  tx_ctrl_skip_cnt
    );
endinterface

// File: rtl/tcp_tx_ctrl.sv
// Transmit control FSM: walks one scheduler request through state read, calc and
// the independent packet / scheduler-update handshakes, counting packetless requests.
module tcp_tx_ctrl
    import tcp_misc_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    tcp_tx_ctrl_if.master bus
);

    tcp_tx_ctrl_state_e state_reg, state_next;
    logic               first_reg;
    logic               produce_reg;
    logic               pkt_done_reg;
    logic               upd_done_reg;
    logic [CNT_W-1:0]   skip_cnt_reg;

    logic in_output;
    logic produce;
    logic pkt_val;
    logic upd_val;
    logic pkt_fire;
    logic upd_fire;
    logic exit_output;

    // On the first OUTPUT cycle the flag is not registered yet, so use the live input.
    assign in_output   = (state_reg == ST_OUTPUT);
    assign produce     = first_reg ? bus.datap_ctrl_produce_pkt : produce_reg;
    assign pkt_val     = in_output && produce && !pkt_done_reg;
    assign upd_val     = in_output && !upd_done_reg;
    assign pkt_fire    = pkt_val && bus.tx_proto_calc_pkt_rdy;
    assign upd_fire    = upd_val && bus.sched_tx_update_rdy;
    assign exit_output = in_output
                         && (!produce || pkt_done_reg || pkt_fire)
                         && (upd_done_reg || upd_fire);

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:    if (bus.sched_tx_req_val) state_next = ST_RD_REQ;
            ST_RD_REQ:  state_next = ST_RD_RESP;
            ST_RD_RESP: state_next = ST_CALC;
            ST_CALC:    state_next = ST_OUTPUT;
            ST_OUTPUT:  if (exit_output) state_next = ST_IDLE;
            default:    state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg    <= ST_IDLE;
            first_reg    <= 1'b0;
            produce_reg  <= 1'b0;
            pkt_done_reg <= 1'b0;
            upd_done_reg <= 1'b0;
            skip_cnt_reg <= '0;
        end else begin
            state_reg <= state_next;
            first_reg <= (state_reg == ST_CALC);
            if (first_reg) produce_reg <= bus.datap_ctrl_produce_pkt;
            if (exit_output) begin
                pkt_done_reg <= 1'b0;
                upd_done_reg <= 1'b0;
                if (!produce) skip_cnt_reg <= skip_cnt_reg + CNT_W'(1);
            end else begin
                if (pkt_fire) pkt_done_reg <= 1'b1;
                if (upd_fire) upd_done_reg <= 1'b1;
            end
        end
    end

    assign bus.tx_sched_req_rdy        = (state_reg == ST_IDLE);
    assign bus.ctrl_datap_store_flowid = (state_reg == ST_IDLE) && bus.sched_tx_req_val;
    assign bus.tx_state_rd_req_val     = (state_reg == ST_RD_REQ);
    assign bus.ctrl_datap_store_state  = (state_reg == ST_RD_RESP);
    assign bus.ctrl_datap_store_tuple  = (state_reg == ST_RD_RESP);
    assign bus.ctrl_datap_store_calc   = (state_reg == ST_CALC);
    assign bus.tx_state_wr_req_val     = in_output && first_reg && bus.datap_ctrl_produce_pkt;
    assign bus.proto_calc_tx_pkt_val   = pkt_val;
    assign bus.tx_sched_update_val     = upd_val;
    assign bus.tx_ctrl_skip_cnt        = skip_cnt_reg;

endmodule

// File: tb/tb_tcp_tx_ctrl.sv
// Directed bench for tcp_tx_ctrl: cycle-exact strobe vectors, stalls, reset
// mid-request, skip counter wrap and a held-request random-ready soak.
module tb_tcp_tx_ctrl;

    localparam int CNT_W = 3;

    logic clk;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    tcp_tx_ctrl_if #(.CNT_W(CNT_W)) bus ();

    tcp_tx_ctrl #(.CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {req_rdy, rd, wr, flowid, state, tuple, calc, pkt_val, upd_val}
    logic [8:0] outs;
    assign outs = {bus.tx_sched_req_rdy, bus.tx_state_rd_req_val, bus.tx_state_wr_req_val,
                   bus.ctrl_datap_store_flowid, bus.ctrl_datap_store_state,
                   bus.ctrl_datap_store_tuple, bus.ctrl_datap_store_calc,
                   bus.proto_calc_tx_pkt_val, bus.tx_sched_update_val};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step(input logic req, input logic prod, input logic prdy, input logic urdy,
                        input logic [8:0] exp, input string tag);
        @(negedge clk);
        bus.sched_tx_req_val       = req;
        bus.datap_ctrl_produce_pkt = prod;
        bus.tx_proto_calc_pkt_rdy  = prdy;
        bus.sched_tx_update_rdy    = urdy;
        #1;
        chk(tag, 32'(outs), 32'(exp));
    endtask

    task automatic full_req(input logic prod, input string tag);
        step(1'b1, 1'b0, 1'b1, 1'b1, 9'h120, {tag, "_c0"});
        step(1'b0, 1'b0, 1'b1, 1'b1, 9'h080, {tag, "_c1"});
        step(1'b0, 1'b0, 1'b1, 1'b1, 9'h018, {tag, "_c2"});
        step(1'b0, 1'b0, 1'b1, 1'b1, 9'h004, {tag, "_c3"});
        step(1'b0, prod, 1'b1, 1'b1, prod ? 9'h043 : 9'h001, {tag, "_c4"});
        step(1'b0, 1'b0, 1'b1, 1'b1, 9'h100, {tag, "_c5"});
        $display("req %s produce=%0d skip_cnt=%0d", tag, prod, bus.tx_ctrl_skip_cnt);
    endtask

    initial begin
        int nflow;
        int nupd;
        rst_n                      = 1'b0;
        bus.sched_tx_req_val       = 1'b0;
        bus.datap_ctrl_produce_pkt = 1'b0;
        bus.tx_proto_calc_pkt_rdy  = 1'b0;
        bus.sched_tx_update_rdy    = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("reset_outs", 32'(outs), 32'h100);
        chk("reset_skip", 32'(bus.tx_ctrl_skip_cnt), 0);

        // Basic request with a packet, both readies high
        full_req(1'b1, "pkt");
        chk("pkt_skip", 32'(bus.tx_ctrl_skip_cnt), 0);

        // Packetless request bumps the skip counter on completion
        full_req(1'b0, "skip");
        chk("skip_cnt1", 32'(bus.tx_ctrl_skip_cnt), 1);

        // Packet assembler stalls 7 OUTPUT cycles; produce input drops to prove the flag holds
        step(1'b1, 1'b0, 1'b0, 1'b1, 9'h120, "stall_c0");
        step(1'b0, 1'b0, 1'b0, 1'b1, 9'h080, "stall_c1");
        step(1'b0, 1'b0, 1'b0, 1'b1, 9'h018, "stall_c2");
        step(1'b0, 1'b0, 1'b0, 1'b1, 9'h004, "stall_c3");
        step(1'b0, 1'b1, 1'b0, 1'b1, 9'h043, "stall_c4");
        for (int i = 0; i < 6; i++)
            step(1'b1, 1'b0, 1'b0, 1'b1, 9'h002, "stall_wait");
        step(1'b0, 1'b0, 1'b1, 1'b1, 9'h002, "stall_last");
        step(1'b0, 1'b0, 1'b1, 1'b1, 9'h100, "stall_idle");
        chk("stall_skip", 32'(bus.tx_ctrl_skip_cnt), 1);
        $display("req stall produce=1 skip_cnt=%0d", bus.tx_ctrl_skip_cnt);

        // Reset asserted for one edge while in CALC
        step(1'b1, 1'b1, 1'b1, 1'b1, 9'h120, "rst_c0");
        step(1'b0, 1'b1, 1'b1, 1'b1, 9'h080, "rst_c1");
        step(1'b0, 1'b1, 1'b1, 1'b1, 9'h018, "rst_c2");
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rst_calc", 32'(outs), 32'h004);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step(1'b0, 1'b1, 1'b1, 1'b1, 9'h100, "rst_after");
        chk("rst_skip", 32'(bus.tx_ctrl_skip_cnt), 0);
        step(1'b0, 1'b1, 1'b1, 1'b1, 9'h100, "rst_quiet1");
        step(1'b0, 1'b1, 1'b1, 1'b1, 9'h100, "rst_quiet2");
        $display("req reset_mid_calc abandoned skip_cnt=%0d", bus.tx_ctrl_skip_cnt);

        // Drive the counter to its max then wrap
        for (int i = 0; i < 7; i++) full_req(1'b0, "fill");
        chk("skip_max", 32'(bus.tx_ctrl_skip_cnt), 7);
        full_req(1'b0, "wrap");
        chk("skip_wrap", 32'(bus.tx_ctrl_skip_cnt), 0);

        // Request held high with random readies and produce
        nflow = 0;
        nupd  = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            bus.sched_tx_req_val       = 1'b1;
            bus.datap_ctrl_produce_pkt = 1'($urandom_range(0, 1));
            bus.tx_proto_calc_pkt_rdy  = 1'($urandom_range(0, 1));
            bus.sched_tx_update_rdy    = 1'($urandom_range(0, 1));
            #1;
            if (bus.ctrl_datap_store_flowid) begin
                nflow++;
                chk("flowid_in_idle", 32'(bus.tx_sched_req_rdy), 1);
            end
            if (bus.tx_sched_update_val && bus.sched_tx_update_rdy) nupd++;
        end
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            bus.sched_tx_req_val      = 1'b0;
            bus.tx_proto_calc_pkt_rdy = 1'b1;
            bus.sched_tx_update_rdy   = 1'b1;
            #1;
            if (bus.ctrl_datap_store_flowid) nflow++;
            if (bus.tx_sched_update_val && bus.sched_tx_update_rdy) nupd++;
        end
        chk("soak_flow_vs_upd", 32'(nflow), 32'(nupd));
        chk("soak_progress", 32'(nflow > 10), 1);
        chk("soak_idle", 32'(outs), 32'h100);
        $display("soak requests=%0d updates=%0d", nflow, nupd);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
